fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Holds the PC and issues word reads to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Supports redirects (branch/jump/trap) with flush of buffered and in-flight fetches, plus a halt request.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/inst_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: FSM states, buffered instruction entry, NOP encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries; a push is visible at head the next cycle.
// No internal backpressure: the producer's credit check prevents overflow; flush beats push.
module inst_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             pushData,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_pop;

  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    do_pop = pop && (cnt_q != '0);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = pushData;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, 1-cycle imem reads, FIFO to decode; request to instValid is 2 cycles.
// Issues only when buffer slots cover everything in flight; decode stalls via instReady.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  output logic [31:0] instOut,
  output logic [31:0] pcOut,
  output logic        instValid,
  input  logic        instReady,
  input  logic        redirectEn,
  input  logic [31:0] redirectPc,
  input  logic        haltReq,
  output logic        halted
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;

  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_wdata;
  logic          fifo_empty;
  logic          fifo_push;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic [CW:0]   credit_used;
  logic          issue;

  always_comb begin
    pop         = instValid && instReady;
    credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue       = !rst && (state_q == RUN) && !redirectEn && (credit_used < DEPTH_W);

    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!redirectEn && haltReq) state_d = HALTED;
      HALTED:  if (redirectEn) state_d = RUN;
      default: state_d = BOOT;
    endcase

    pc_d = pc_q;
    if (redirectEn) begin
      pc_d = redirectPc & ~32'h3;
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end

    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;

    // A response landing in the redirect cycle is stale; nothing is issued during
    // redirect, so the cycle after can never carry a pre-redirect response.
    fifo_push  = inflight_q && !redirectEn;
    fifo_wdata = '{pc: inflight_pc_q, inst: imemRdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirectEn),
    .push     (fifo_push),
    .pushData (fifo_wdata),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign imemReq   = issue;
  assign imemAddr  = pc_q;
  assign instValid = !fifo_empty;
  assign instOut   = fifo_empty ? INST_NOP : fifo_head.inst;
  assign pcOut     = fifo_empty ? 32'h0 : fifo_head.pc;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences, and a
// randomized run checked every cycle against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata = 32'hDEAD_BEEF;
  logic [31:0] instOut;
  logic [31:0] pcOut;
  logic        instValid;
  logic        instReady = 1'b0;
  logic        redirectEn = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        haltReq = 1'b0;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemRdata  (imemRdata),
    .instOut    (instOut),
    .pcOut      (pcOut),
    .instValid  (instValid),
    .instReady  (instReady),
    .redirectEn (redirectEn),
    .redirectPc (redirectPc),
    .haltReq    (haltReq),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Program image: word 0 is a NOP, word k is "addi x1, x0, 5*k".
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    if (a == 32'h0) return 32'h0000_0013;
    k = (a >> 2) * 32'd5;
    return {k[11:0], 20'h00093};
  endfunction

  // Instruction memory with a fixed one-cycle read latency.
  always @(posedge clk) imemRdata <= imemReq ? mem_word(imemAddr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of delivered entries, at most one outstanding read.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  bit          m_ok = 0;
  int          m_st;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ppc;

  task automatic step(input logic r, input logic rdy, input logic rd,
                      input logic [31:0] rpc, input logic h);
    bit v, pop, iss;
    int used;
    @(negedge clk);
    rst = r; instReady = rdy; redirectEn = rd; redirectPc = rpc; haltReq = h;
    #1;
    if (m_ok) begin
      v    = (mq.size() > 0);
      pop  = v && rdy;
      used = mq.size() + int'(m_pend) - int'(pop);
      iss  = !r && (m_st == M_RUN) && !rd && (used < DEPTH);
      chk("imemReq", imemReq, iss);
      if (iss) chk("imemAddr", imemAddr, m_pc);
      chk("instValid", instValid, v);
      chk("instOut", instOut, v ? mq[0].inst : NOP);
      chk("pcOut", pcOut, v ? mq[0].pc : 32'h0);
      chk("halted", halted, m_st == M_HALT);
      if (!r) begin
        if (pop) void'(mq.pop_front());
        if (rd) mq.delete();
        else if (m_pend) begin
          mq.push_back('{m_ppc, mem_word(m_ppc)});
          chk("no_overflow", mq.size() <= DEPTH, 1);
        end
        m_pend = iss;
        if (iss) m_ppc = m_pc;
        if (rd) m_pc = rpc & ~32'h3;
        else if (iss) m_pc = m_pc + 32'd4;
        case (m_st)
          M_BOOT:  m_st = M_RUN;
          M_RUN:   if (!rd && h) m_st = M_HALT;
          default: if (rd) m_st = M_RUN;
        endcase
      end
    end
    if (r) begin
      mq.delete(); m_pend = 0; m_pc = RESET_PC; m_st = M_BOOT; m_ok = 1;
    end
  endtask

  typedef struct {
    logic rdy; logic e_req; logic [31:0] e_addr;
    logic e_vld; logic [31:0] e_pc; logic [31:0] e_inst;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rdy, input logic req, input logic [31:0] addr,
                     input logic vld, input logic [31:0] pc, input logic [31:0] inst);
    tbl.push_back('{rdy, req, addr, vld, pc, inst});
  endtask

  initial begin
    logic [31:0] h_addr;
    logic [31:0] rpc;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Startup, steady stream, 10-cycle stall, then drain.
    add(1, 0, 32'h00, 0, 32'h00, NOP);
    add(1, 1, 32'h00, 0, 32'h00, NOP);
    add(1, 1, 32'h04, 0, 32'h00, NOP);
    add(1, 1, 32'h08, 1, 32'h00, 32'h0000_0013);
    add(1, 1, 32'h0C, 1, 32'h04, 32'h0050_0093);
    add(1, 1, 32'h10, 1, 32'h08, 32'h00A0_0093);
    add(1, 1, 32'h14, 1, 32'h0C, 32'h00F0_0093);
    for (int i = 0; i < 10; i++) add(0, 0, 32'h18, 1, 32'h10, 32'h0140_0093);
    add(1, 1, 32'h18, 1, 32'h10, 32'h0140_0093);
    add(1, 1, 32'h1C, 1, 32'h14, 32'h0190_0093);
    add(1, 1, 32'h20, 1, 32'h18, 32'h01E0_0093);
    add(1, 1, 32'h24, 1, 32'h1C, 32'h0230_0093);
    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].rdy, 0, 0, 0);
      chk($sformatf("tbl%0d_req", i), imemReq, tbl[i].e_req);
      chk($sformatf("tbl%0d_addr", i), imemAddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_vld", i), instValid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_pc", i), pcOut, tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst", i), instOut, tbl[i].e_inst);
      if (i == 0) chk("reset_halted", halted, 0);
    end

    // Redirect with a buffered entry and a read in flight; stale data is dropped.
    step(0, 0, 1, 32'h0000_0103, 0);
    chk("redir_noreq", imemReq, 0);
    step(0, 1, 0, 0, 0);
    chk("redir_flushed", instValid, 0);
    chk("redir_req", imemReq, 1);
    chk("redir_addr", imemAddr, 32'h100);
    step(0, 1, 0, 0, 0);
    chk("redir_vld2", instValid, 0);
    step(0, 1, 0, 0, 0);
    chk("redir_vld3", instValid, 1);
    chk("redir_pc3", pcOut, 32'h100);
    chk("redir_inst3", instOut, 32'h1400_0093);

    // PC wrap at the top of the address space.
    step(0, 1, 1, 32'hFFFF_FFF8, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("wrap_pc0", pcOut, 32'hFFFF_FFF8);
    step(0, 1, 0, 0, 0);
    chk("wrap_pc1", pcOut, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0);
    chk("wrap_pc2", pcOut, 32'h0000_0000);

    // Halt pulse: the read issued in the halt cycle is still delivered.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    chk("halt_cycle_req", imemReq, 1);
    h_addr = imemAddr;
    step(0, 1, 0, 0, 0);
    chk("halt_flag", halted, 1);
    chk("halt_noreq1", imemReq, 0);
    step(0, 1, 0, 0, 0);
    chk("halt_noreq2", imemReq, 0);
    chk("halt_deliver_vld", instValid, 1);
    chk("halt_deliver_pc", pcOut, h_addr);
    step(0, 1, 0, 0, 1);
    chk("halt_noreq3", imemReq, 0);
    chk("halt_drained", instValid, 0);
    step(0, 1, 1, 32'h0000_0040, 0);
    step(0, 1, 0, 0, 0);
    chk("resume_halted", halted, 0);
    chk("resume_req", imemReq, 1);
    chk("resume_addr", imemAddr, 32'h40);

    // Reset mid-stream with a read in flight.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("rst_vld", instValid, 0);
    chk("rst_noreq", imemReq, 0);
    chk("rst_addr", imemAddr, RESET_PC);
    step(0, 1, 0, 0, 0);
    chk("rst_first_req", imemReq, 1);
    chk("rst_first_addr", imemAddr, RESET_PC);
    step(0, 1, 0, 0, 0);
    chk("rst_no_stale", instValid, 0);
    step(0, 1, 0, 0, 0);
    chk("rst_pc", pcOut, RESET_PC);
    chk("rst_inst", instOut, 32'h0000_0013);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 32) == 0,
           rpc,
           $urandom_range(0, 32) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
